// File: rtl/cache_pkg.sv
// Shared types, width helpers and load/store lane functions for the N-way cache array.
package cache_pkg;

  // RV32I width codes: [1]=word, [0]=half, [2]=unsigned
  localparam logic [2:0] UBHW_LB  = 3'b000;
  localparam logic [2:0] UBHW_LH  = 3'b001;
  localparam logic [2:0] UBHW_LW  = 3'b010;
  localparam logic [2:0] UBHW_LBU = 3'b100;
  localparam logic [2:0] UBHW_LHU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WALK = 2'd1,
    DONE = 2'd2
  } flush_state_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r = r + 1;
    return r;
  endfunction

  function automatic int tag_bits(input int addr_bits, input int sets, input int line_words);
    return addr_bits - clog2(sets) - clog2(line_words) - 2;
  endfunction

  // Select word/half/byte from a 32-bit word and extend it to 32 bits.
  function automatic logic [31:0] load_extract(input logic [31:0] word, input logic [2:0] ubhw,
                                               input logic [1:0] boff);
    logic [15:0] h;
    logic [7:0]  b;
    logic [31:0] r;
    h = boff[1] ? word[31:16] : word[15:0];
    b = word[{boff, 3'b000} +: 8];
    if (ubhw[1])      r = word;
    else if (ubhw[0]) r = ubhw[2] ? {16'h0000, h} : {{16{h[15]}}, h};
    else              r = ubhw[2] ? {24'h000000, b} : {{24{b[7]}}, b};
    return r;
  endfunction

  function automatic logic [31:0] store_merge(input logic [31:0] old, input logic [31:0] din,
                                              input logic [2:0] ubhw, input logic [1:0] boff);
    logic [31:0] r;
    r = old;
    if (ubhw[1]) begin
      r = din;
    end else if (ubhw[0]) begin
      if (boff[1]) r[31:16] = din[15:0];
      else         r[15:0]  = din[15:0];
    end else begin
      r[{boff, 3'b000} +: 8] = din[7:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/cache_lru_age.sv
// True-LRU age update for one set: the hit way becomes youngest, younger ways age by one.
module cache_lru_age #(
  parameter int WAYS  = 4,
  parameter int AGE_W = 2
) (
  input  logic [WAYS-1:0][AGE_W-1:0] ages,
  input  logic [AGE_W-1:0]           hit_way,
  output logic [WAYS-1:0][AGE_W-1:0] new_ages,
  output logic [AGE_W-1:0]           max_way
);

  logic [AGE_W-1:0] hit_age;
  assign hit_age = ages[hit_way];

  for (genvar gi = 0; gi < WAYS; gi++) begin : g_age
    assign new_ages[gi] = (AGE_W'(gi) == hit_way) ? '0 :
                          (ages[gi] < hit_age)    ? ages[gi] + AGE_W'(1) :
                                                    ages[gi];
  end

  always_comb begin
    max_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (ages[w] == AGE_W'(WAYS - 1)) max_way = AGE_W'(w);
    end
  end

endmodule

// File: rtl/cache_nway_lru.sv
// N-way set-associative cache array: lookup, LRU ages, byte/half/word access,
// latched fill way for multi-word line fills and a one-set-per-cycle flush walker.
module cache_nway_lru
  import cache_pkg::*;
#(
  parameter  int ADDR_BITS  = 32,
  parameter  int WAYS       = 4,
  parameter  int SETS       = 32,
  parameter  int LINE_WORDS = 4,
  localparam int IDX_W      = clog2(SETS),
  localparam int WOFF_W     = clog2(LINE_WORDS),
  localparam int AGE_W      = clog2(WAYS),
  localparam int TAG_BITS   = ADDR_BITS - IDX_W - WOFF_W - 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [ADDR_BITS-1:0] addr,
  input  logic                 load,
  input  logic                 edit,
  input  logic                 store,
  input  logic                 invalid,
  input  logic                 flush_req,
  input  logic [2:0]           u_b_h_w,
  input  logic [31:0]          din,
  output logic                 hit,
  output logic [31:0]          dout,
  output logic                 valid,
  output logic                 dirty,
  output logic [TAG_BITS-1:0]  tag,
  output logic [AGE_W-1:0]     victim_way,
  output logic                 flush_busy,
  output logic                 flush_done
);

  localparam int WOFF_SZ = (WOFF_W > 0) ? WOFF_W : 1;
  localparam int DA_W    = IDX_W + WOFF_W;

  logic [IDX_W-1:0]    idx;
  logic [WOFF_SZ-1:0]  woff;
  logic [DA_W-1:0]     daddr;
  logic [TAG_BITS-1:0] atag;
  logic [1:0]          boff;

  assign idx  = addr[IDX_W+WOFF_W+1 -: IDX_W];
  assign atag = addr[ADDR_BITS-1 -: TAG_BITS];
  assign boff = addr[1:0];

  if (WOFF_W > 0) begin : g_woff
    assign woff  = addr[WOFF_W+1:2];
    assign daddr = {idx, woff};
  end else begin : g_nowoff
    assign woff  = '0;
    assign daddr = idx;
  end

  // Control state is in flops; tag/data are plain arrays left unreset.
  logic [WAYS-1:0]             valid_reg [SETS];
  logic [WAYS-1:0]             dirty_reg [SETS];
  logic [WAYS-1:0][AGE_W-1:0]  age_reg   [SETS];
  logic [TAG_BITS-1:0]         tag_mem   [WAYS][SETS];
  logic [31:0]                 data_mem  [WAYS][SETS*LINE_WORDS];

  logic [AGE_W-1:0]            fill_way_reg;
  flush_state_t                state_reg, state_next;
  logic [IDX_W-1:0]            cnt_reg, cnt_next;

  logic [WAYS-1:0][AGE_W-1:0]  init_ages, new_ages;
  logic [WAYS-1:0]             hit_vec;
  logic                        hit_any;
  logic [AGE_W-1:0]            hit_way, victim, max_way, sel_way, fill_sel;
  logic [31:0]                 hit_word, vic_word;
  logic                        busy, first_word, last_word;
  logic                        do_inv, do_store, do_edit, lru_upd;
  logic                        mem_we;
  logic [AGE_W-1:0]            mem_way;
  logic [31:0]                 mem_wdata;

  for (genvar gi = 0; gi < WAYS; gi++) begin : g_way
    assign init_ages[gi] = AGE_W'(gi);
    assign hit_vec[gi]   = valid_reg[idx][gi] && (tag_mem[gi][idx] == atag);
  end

  assign hit_any = |hit_vec;

  always_comb begin
    hit_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (hit_vec[w]) hit_way = AGE_W'(w);
    end
  end

  cache_lru_age #(
    .WAYS  (WAYS),
    .AGE_W (AGE_W)
  ) u_age (
    .ages     (age_reg[idx]),
    .hit_way  (hit_way),
    .new_ages (new_ages),
    .max_way  (max_way)
  );

  // Lowest-index invalid way wins; the oldest way is only used when the set is full.
  always_comb begin
    logic found;
    found  = 1'b0;
    victim = max_way;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid_reg[idx][w]) begin
        victim = AGE_W'(w);
        found  = 1'b1;
      end
    end
    if (!found) victim = max_way;
  end

  assign sel_way    = hit_any ? hit_way : victim;
  assign hit_word   = data_mem[hit_way][daddr];
  assign vic_word   = data_mem[victim][daddr];
  assign busy       = (state_reg == WALK);
  assign first_word = (woff == '0);
  assign last_word  = (woff == WOFF_SZ'(LINE_WORDS - 1));
  assign fill_sel   = first_word ? victim : fill_way_reg;

  assign do_inv   = invalid & ~busy;
  assign do_store = store & ~busy & ~invalid;
  assign do_edit  = edit & hit_any & ~busy & ~invalid & ~store;
  assign lru_upd  = hit_any & (load | do_edit) & ~busy & ~invalid;

  always_comb begin
    mem_we    = 1'b0;
    mem_way   = fill_sel;
    mem_wdata = din;
    if (do_store) begin
      mem_we = 1'b1;
    end else if (do_edit) begin
      mem_we    = 1'b1;
      mem_way   = hit_way;
      mem_wdata = store_merge(hit_word, din, u_b_h_w, boff);
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) data_mem[mem_way][daddr] <= mem_wdata;
    if (do_store && last_word) tag_mem[fill_sel][idx] <= atag;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < SETS; s++) begin
        valid_reg[s] <= '0;
        dirty_reg[s] <= '0;
        age_reg[s]   <= init_ages;
      end
      fill_way_reg <= '0;
    end else if (busy) begin
      valid_reg[cnt_reg] <= '0;
      dirty_reg[cnt_reg] <= '0;
      age_reg[cnt_reg]   <= init_ages;
    end else if (do_inv) begin
      valid_reg[idx] <= '0;
      dirty_reg[idx] <= '0;
      age_reg[idx]   <= init_ages;
    end else begin
      if (do_store && first_word) fill_way_reg <= victim;
      if (do_store && last_word) begin
        valid_reg[idx][fill_sel] <= 1'b1;
        dirty_reg[idx][fill_sel] <= 1'b0;
      end
      if (do_edit) dirty_reg[idx][hit_way] <= 1'b1;
      if (lru_upd) age_reg[idx] <= new_ages;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      IDLE: if (flush_req) begin
        state_next = WALK;
        cnt_next   = '0;
      end
      WALK: begin
        if (cnt_reg == IDX_W'(SETS - 1)) state_next = DONE;
        else                             cnt_next   = cnt_reg + IDX_W'(1);
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  assign flush_busy = (state_reg == WALK);
  assign flush_done = (state_reg == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit        <= 1'b0;
      dout       <= '0;
      valid      <= 1'b0;
      dirty      <= 1'b0;
      tag        <= '0;
      victim_way <= '0;
    end else begin
      hit <= hit_any & ~busy;
      if (!busy) begin
        if (!load)        dout <= vic_word;
        else if (hit_any) dout <= load_extract(hit_word, u_b_h_w, boff);
        else              dout <= '0;
      end
      valid      <= valid_reg[idx][sel_way];
      dirty      <= dirty_reg[idx][sel_way];
      tag        <= tag_mem[sel_way][idx];
      victim_way <= victim;
    end
  end

endmodule

// File: tb/tb_cache_nway_lru.sv
// Directed test of cache_nway_lru (4 ways, 32 sets, 4-word lines) with hand-computed expectations.
module tb_cache_nway_lru;
  import cache_pkg::*;

  localparam int TAG_BITS = 23;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [31:0]         addr;
  logic                load, edit, store, invalid, flush_req;
  logic [2:0]          u_b_h_w;
  logic [31:0]         din;
  logic                hit, valid, dirty, flush_busy, flush_done;
  logic [31:0]         dout;
  logic [TAG_BITS-1:0] tag;
  logic [1:0]          victim_way;

  int n_checks = 0;
  int n_fail   = 0;
  int busy_cnt, done_cnt;

  always #5 clk = ~clk;

  cache_nway_lru #(
    .ADDR_BITS  (32),
    .WAYS       (4),
    .SETS       (32),
    .LINE_WORDS (4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .addr       (addr),
    .load       (load),
    .edit       (edit),
    .store      (store),
    .invalid    (invalid),
    .flush_req  (flush_req),
    .u_b_h_w    (u_b_h_w),
    .din        (din),
    .hit        (hit),
    .dout       (dout),
    .valid      (valid),
    .dirty      (dirty),
    .tag        (tag),
    .victim_way (victim_way),
    .flush_busy (flush_busy),
    .flush_done (flush_done)
  );

  function automatic logic [31:0] mk(input int t, input int s, input int wo, input int bo);
    return (32'(t) << 9) | (32'(s) << 4) | (32'(wo) << 2) | 32'(bo);
  endfunction

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", name, obs, exp);
    end
  endtask

  task automatic op(input logic ld, input logic ed, input logic st, input logic inv, input logic fr,
                    input logic [2:0] w, input logic [31:0] a, input logic [31:0] d);
    load = ld; edit = ed; store = st; invalid = inv; flush_req = fr;
    u_b_h_w = w; addr = a; din = d;
    @(posedge clk); #1;
    $display("op ld=%b ed=%b st=%b inv=%b fr=%b w=%03b addr=%08h din=%08h -> hit=%b dout=%08h v=%b d=%b tag=%0h vic=%0d busy=%b done=%b",
             ld, ed, st, inv, fr, w, a, d, hit, dout, valid, dirty, tag, victim_way, flush_busy, flush_done);
    load = 0; edit = 0; store = 0; invalid = 0; flush_req = 0;
  endtask

  task automatic ld(input logic [2:0] w, input logic [31:0] a);
    op(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, w, a, 32'h0);
  endtask

  task automatic fill(input int t, input int s, input logic [31:0] base);
    for (int k = 0; k < 4; k++) op(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, UBHW_LW, mk(t, s, k, 0), base + 32'(k));
  endtask

  initial begin
    rst_n = 1'b1;
    load = 0; edit = 0; store = 0; invalid = 0; flush_req = 0;
    u_b_h_w = UBHW_LW; addr = '0; din = '0;
    #1 rst_n = 1'b0;
    #3;
    check("rst_hit", 32'(hit), 0);
    check("rst_dout", dout, 0);
    check("rst_valid", 32'(valid), 0);
    check("rst_dirty", 32'(dirty), 0);
    check("rst_victim", 32'(victim_way), 0);
    check("rst_busy", 32'(flush_busy), 0);
    check("rst_done", 32'(flush_done), 0);
    #8 rst_n = 1'b1;
    @(posedge clk); #1;

    // 1: cold miss
    ld(UBHW_LW, 32'h0000_0100);
    check("t1_hit", 32'(hit), 0);
    check("t1_valid", 32'(valid), 0);
    check("t1_victim", 32'(victim_way), 0);
    check("t1_dout", dout, 0);

    // 2: fill set 0 tag 1 and read word 2
    fill(1, 0, 32'hA0);
    ld(UBHW_LW, mk(1, 0, 2, 0));
    check("t2_hit", 32'(hit), 1);
    check("t2_dout", dout, 32'hA2);
    check("t2_valid", 32'(valid), 1);
    check("t2_dirty", 32'(dirty), 0);
    check("t2_tag", 32'(tag), 1);
    check("t2_victim", 32'(victim_way), 1);
    check("t2_age_w0", 32'(dut.age_reg[0][0]), 0);

    // 3: byte/half edits and sign/zero extension
    op(0, 0, 1, 0, 0, UBHW_LW, mk(2, 1, 0, 0), 32'h1122_3344);
    op(0, 0, 1, 0, 0, UBHW_LW, mk(2, 1, 1, 0), 32'hB1);
    op(0, 0, 1, 0, 0, UBHW_LW, mk(2, 1, 2, 0), 32'hB2);
    op(0, 0, 1, 0, 0, UBHW_LW, mk(2, 1, 3, 0), 32'hB3);
    op(0, 1, 0, 0, 0, UBHW_LB, mk(2, 1, 0, 3), 32'h80);
    ld(UBHW_LB, mk(2, 1, 0, 3));
    check("t3_lb", dout, 32'hFFFF_FF80);
    check("t3_dirty", 32'(dirty), 1);
    ld(UBHW_LBU, mk(2, 1, 0, 3));
    check("t3_lbu", dout, 32'h0000_0080);
    ld(UBHW_LW, mk(2, 1, 0, 0));
    check("t3_lw", dout, 32'h8022_3344);
    ld(UBHW_LH, mk(2, 1, 0, 2));
    check("t3_lh", dout, 32'hFFFF_8022);
    ld(UBHW_LHU, mk(2, 1, 0, 3));
    check("t3_lhu", dout, 32'h0000_8022);
    ld(UBHW_LB, mk(2, 1, 0, 1));
    check("t3_lb1", dout, 32'h0000_0033);
    op(0, 1, 0, 0, 0, UBHW_LH, mk(2, 1, 1, 0), 32'h0000_BEEF);
    ld(UBHW_LW, mk(2, 1, 1, 0));
    check("t3_sh", dout, 32'h0000_BEEF);
    op(0, 1, 0, 0, 0, UBHW_LW, mk(3, 1, 0, 0), 32'hDEAD_BEEF);
    ld(UBHW_LW, mk(2, 1, 0, 0));
    check("t3_editmiss", dout, 32'h8022_3344);
    ld(UBHW_LW, mk(3, 1, 0, 0));
    check("t3_missh", 32'(hit), 0);

    // 4: LRU victim choice in set 5
    fill(10, 5, 32'h5A0);
    fill(11, 5, 32'h5B0);
    fill(12, 5, 32'h5C0);
    fill(13, 5, 32'h5D0);
    op(0, 1, 0, 0, 0, UBHW_LW, mk(13, 5, 0, 0), 32'hCAFE_F00D);
    ld(UBHW_LW, mk(10, 5, 0, 0));
    check("t4_ld10", dout, 32'h5A0);
    ld(UBHW_LW, mk(11, 5, 0, 0));
    check("t4_ld11", dout, 32'h5B0);
    ld(UBHW_LW, mk(12, 5, 1, 0));
    check("t4_ld12", dout, 32'h5C1);
    ld(UBHW_LW, mk(14, 5, 0, 0));
    check("t4_hit", 32'(hit), 0);
    check("t4_victim", 32'(victim_way), 3);
    check("t4_valid", 32'(valid), 1);
    check("t4_dirty", 32'(dirty), 1);
    check("t4_tag", 32'(tag), 13);
    check("t4_dout", dout, 0);
    op(0, 0, 0, 0, 0, UBHW_LW, mk(14, 5, 1, 0), 32'h0);
    check("t4_wb1", dout, 32'h5D1);
    op(0, 0, 0, 0, 0, UBHW_LW, mk(14, 5, 0, 0), 32'h0);
    check("t4_wb0", dout, 32'hCAFE_F00D);

    // 5: fill everything, then flush
    for (int s = 0; s < 32; s++)
      for (int t = 100; t < 104; t++)
        fill(t, s, 32'h7000_0000 | (32'(s) << 8) | (32'(t - 100) << 4));
    op(1, 0, 0, 0, 1, UBHW_LW, mk(103, 31, 0, 0), 32'h0);
    check("t5_prehit", 32'(hit), 1);
    check("t5_predout", dout, 32'h7000_1F30);
    check("t5_busy0", 32'(flush_busy), 1);
    busy_cnt = int'(flush_busy);
    done_cnt = int'(flush_done);
    ld(UBHW_LW, mk(101, 31, 1, 0));
    check("t5_busyhit", 32'(hit), 0);
    check("t5_busydout", dout, 32'h7000_1F30);
    busy_cnt += int'(flush_busy);
    done_cnt += int'(flush_done);
    for (int i = 0; i < 35; i++) begin
      @(posedge clk); #1;
      busy_cnt += int'(flush_busy);
      done_cnt += int'(flush_done);
    end
    check("t5_busycnt", 32'(busy_cnt), 32);
    check("t5_donecnt", 32'(done_cnt), 1);
    ld(UBHW_LW, mk(103, 31, 0, 0));
    check("t5_miss31", 32'(hit), 0);
    check("t5_valid31", 32'(valid), 0);
    ld(UBHW_LW, mk(102, 16, 3, 0));
    check("t5_miss16", 32'(hit), 0);
    check("t5_vic16", 32'(victim_way), 0);
    ld(UBHW_LW, mk(100, 0, 0, 0));
    check("t5_miss0", 32'(hit), 0);

    // 6: invalid beats store; invalid clears a valid line
    op(0, 0, 1, 0, 0, UBHW_LW, mk(20, 7, 0, 0), 32'h70);
    op(0, 0, 1, 0, 0, UBHW_LW, mk(20, 7, 1, 0), 32'h71);
    op(0, 0, 1, 0, 0, UBHW_LW, mk(20, 7, 2, 0), 32'h72);
    op(0, 0, 1, 1, 0, UBHW_LW, mk(20, 7, 3, 0), 32'h73);
    ld(UBHW_LW, mk(20, 7, 0, 0));
    check("t6_stinv_hit", 32'(hit), 0);
    check("t6_stinv_valid", 32'(valid), 0);
    fill(21, 8, 32'h800);
    ld(UBHW_LW, mk(21, 8, 3, 0));
    check("t6_prehit", 32'(hit), 1);
    check("t6_predout", dout, 32'h803);
    op(0, 0, 0, 1, 0, UBHW_LW, mk(21, 8, 0, 0), 32'h0);
    ld(UBHW_LW, mk(21, 8, 3, 0));
    check("t6_inv_hit", 32'(hit), 0);
    check("t6_inv_valid", 32'(valid), 0);

    // reset in the middle of a flush
    fill(30, 31, 32'h900);
    op(0, 0, 0, 0, 1, UBHW_LW, mk(0, 0, 0, 0), 32'h0);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
    end
    check("t6_midbusy", 32'(flush_busy), 1);
    rst_n = 1'b0;
    #1;
    check("t6_rstbusy", 32'(flush_busy), 0);
    check("t6_rstdone", 32'(flush_done), 0);
    @(negedge clk);
    rst_n = 1'b1;
    done_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      done_cnt += int'(flush_done);
    end
    check("t6_nodone", 32'(done_cnt), 0);
    check("t6_idle", 32'(flush_busy), 0);
    ld(UBHW_LW, mk(30, 31, 0, 0));
    check("t6_rstmiss", 32'(hit), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
